wb_soc_reg_slave: RTL and testbench
===================================

Name: wb_soc_reg_slave

Overview:
- Wishbone classic slave register file for SoC peripherals. Used by the video output block as its configuration and interrupt front-end.
- Holds a 32-bit module register (the frame buffer base address) and flags `initialized` once software has written it.
- Turns a request pulse from the peripheral core into a maskable, software-clearable interrupt line.

Parameters:
- RESET_VALUE, 32'h41000000, reset value of module_register (REG0).
- ID_VALUE, 32'h564F0001, constant returned by the read-only ID register (REG3).

Ports:
- p_clk  in  1  single clock (100 MHz domain); all logic on rising edge.
- p_resetn  in  1  asynchronous, active-low reset.
- raise_irq  in  1  interrupt request from peripheral core; rising edge sets pending.
- irq  out  1  interrupt line to CPU/ICU.
- module_register  out  32  current REG0 contents.
- initialized  out  1  high once REG0 has been written since reset.
- p_wb_DAT_I  in  32  write data.
- p_wb_DAT_O  out  32  read data.
- p_wb_ADR_I  in  32  byte address; only bits [3:2] decoded.
- p_wb_ACK_O  out  1  cycle acknowledge.
- p_wb_CYC_I  in  1  bus cycle.
- p_wb_ERR_O  out  1  error; constant 0.
- p_wb_LOCK_I  in  1  ignored.
- p_wb_RTY_O  out  1  retry; constant 0.
- p_wb_SEL_I  in  4  byte enables; bit n covers data bits [8n+7:8n].
- p_wb_STB_I  in  1  strobe.
- p_wb_WE_I  in  1  1 = write, 0 = read.

Behaviour:
- Reset (async, p_resetn=0):
  - REG0 = RESET_VALUE; initialized = 0.
  - irq_enable = 0; pending = 0; raise_irq edge-detect flop = 0.
  - ACK_O = 0; DAT_O = 0; irq = 0.
  - Reset mid-transfer aborts the transfer; no ACK is issued afterwards for it.
- Register map (word offset = ADR_I[3:2]; higher address bits are not decoded, the interconnect selects the slave):
  - 0 REG0 ADDR, R/W. Byte-masked by SEL_I. Any write with at least one SEL bit set sets initialized=1, sticky until reset.
  - 1 CTRL, R/W. Bit0 = irq_enable. Other bits read 0, writes ignored. Byte lane 0 needs SEL_I[0].
  - 2 STATUS. Bit0 = pending, write-1-to-clear (needs SEL_I[0]). Bit1 = initialized, read-only. Other bits read 0.
  - 3 ID, read-only = ID_VALUE. Writes are acknowledged and have no effect.
- Handshake:
  - A request is CYC_I & STB_I & !ACK_O.
  - ACK_O is registered: high exactly one cycle, the cycle after the request is sampled. Latency is 1 cycle.
  - After an ACK, the next request is accepted at the earliest one cycle later. A held STB yields an ACK every 2 cycles.
  - Write side effects take effect in the same clock edge that raises ACK_O.
  - DAT_O is registered and valid while ACK_O=1. DAT_O returns 0 on a write ACK and when idle.
  - If STB_I/CYC_I drop before the ACK, the pending ACK still fires once. The write is already committed.
- Interrupt:
  - A rising edge of raise_irq (raise_irq=1 while its previous sampled value was 0) sets pending.
  - irq = pending & irq_enable, registered, so it follows a change in pending or enable by 1 cycle.
  - Set and W1C clear in the same cycle: set wins, pending stays 1.
  - Clearing irq_enable masks irq but keeps pending.
- module_register and initialized are driven directly from their flops and update at the write-commit edge.

Test Plan:
- Reset state: after reset, read REG0 -> 0x41000000, with ACK 1 cycle after STB. Read STATUS -> 0, ID -> 0x564F0001, initialized=0, irq=0.
- REG0 write: write 0x40100000 with SEL=4'hF -> module_register=0x40100000 and initialized=1 at the ACK edge. A later SEL=4'b0001 write of 0xFFFFFFAA -> 0x401000AA.
- Interrupt path: enable CTRL=1, pulse raise_irq one cycle -> STATUS=0x3, irq=1. Write STATUS=1 -> irq=0 one cycle later.
- Masking and collision:
  - Pending set with CTRL=0 -> irq=0; then write CTRL=1 -> irq=1.
  - raise_irq rising edge on the same edge as a W1C -> pending remains 1.
- Handshake:
  - STB held for 6 cycles -> ACK pattern 0,1,0,1,0,1.
  - ERR_O=0 and RTY_O=0 throughout.
  - Writes to ID are acknowledged and ignored.
- Async reset mid-cycle: assert p_resetn=0 between STB and ACK -> ACK never appears, REG0 back to 0x41000000, initialized=0.

Source files
------------

// File: rtl/wb_soc_reg_slave.sv
// Wishbone classic register slave: frame buffer base register, irq control/status and ID.
// Single-cycle registered ACK; the rising edge of raise_irq latches a maskable, W1C pending flag.
module wb_soc_reg_slave #(
  parameter logic [31:0] RESET_VALUE = 32'h41000000,
  parameter logic [31:0] ID_VALUE    = 32'h564F0001
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        raise_irq,
  output logic        irq,
  output logic [31:0] module_register,
  output logic        initialized,
  input  logic [31:0] p_wb_DAT_I,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_ADR_I,
  output logic        p_wb_ACK_O,
  input  logic        p_wb_CYC_I,
  output logic        p_wb_ERR_O,
  input  logic        p_wb_LOCK_I,
  output logic        p_wb_RTY_O,
  input  logic [3:0]  p_wb_SEL_I,
  input  logic        p_wb_STB_I,
  input  logic        p_wb_WE_I
);

  localparam int unsigned DW     = 32;
  localparam int unsigned NBYTES = DW / 8;

  localparam logic [1:0] W_REG0   = 2'd0;
  localparam logic [1:0] W_CTRL   = 2'd1;
  localparam logic [1:0] W_STATUS = 2'd2;
  localparam logic [1:0] W_ID     = 2'd3;

  logic [DW-1:0] reg0_q, reg0_d;
  logic          init_q, init_d;
  logic          irq_en_q, irq_en_d;
  logic          pending_q, pending_d;
  logic          raise_prev_q, raise_prev_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          irq_q, irq_d;

  logic          req;
  logic          wr;
  logic          rd;
  logic [1:0]    word;
  logic [DW-1:0] rdata;

  // Address bits above the word offset and LOCK carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{p_wb_ADR_I[31:4], p_wb_ADR_I[1:0], p_wb_LOCK_I};

  assign req  = p_wb_CYC_I & p_wb_STB_I & ~ack_q;
  assign wr   = req & p_wb_WE_I;
  assign rd   = req & ~p_wb_WE_I;
  assign word = p_wb_ADR_I[3:2];

  always_comb begin
    rdata = '0;
    case (word)
      W_REG0:   rdata = reg0_q;
      W_CTRL:   rdata = {31'(0), irq_en_q};
      W_STATUS: rdata = {30'(0), init_q, pending_q};
      W_ID:     rdata = ID_VALUE;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    reg0_d       = reg0_q;
    init_d       = init_q;
    irq_en_d     = irq_en_q;
    pending_d    = pending_q;
    raise_prev_d = raise_irq;
    ack_d        = req;
    dat_d        = '0;
    irq_d        = pending_q & irq_en_q;

    if (wr) begin
      case (word)
        W_REG0: begin
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (p_wb_SEL_I[b]) reg0_d[8*b +: 8] = p_wb_DAT_I[8*b +: 8];
          end
          if (|p_wb_SEL_I) init_d = 1'b1;
        end
        W_CTRL: begin
          if (p_wb_SEL_I[0]) irq_en_d = p_wb_DAT_I[0];
        end
        W_STATUS: begin
          if (p_wb_SEL_I[0] && p_wb_DAT_I[0]) pending_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A new request edge overrides a simultaneous software clear.
    if (raise_irq && !raise_prev_q) pending_d = 1'b1;

    if (rd) dat_d = rdata;
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      reg0_q       <= RESET_VALUE;
      init_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      pending_q    <= 1'b0;
      raise_prev_q <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      reg0_q       <= reg0_d;
      init_q       <= init_d;
      irq_en_q     <= irq_en_d;
      pending_q    <= pending_d;
      raise_prev_q <= raise_prev_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      irq_q        <= irq_d;
    end
  end

  assign module_register = reg0_q;
  assign initialized     = init_q;
  assign irq             = irq_q;
  assign p_wb_ACK_O      = ack_q;
  assign p_wb_DAT_O      = dat_q;
  assign p_wb_ERR_O      = 1'b0;
  assign p_wb_RTY_O      = 1'b0;

endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Directed bench for wb_soc_reg_slave: register access, handshake timing, interrupt path, async reset.
module tb_wb_soc_reg_slave;

  logic        clk;
  logic        rst_n;
  logic        raise_irq;
  logic        irq;
  logic [31:0] module_register;
  logic        initialized;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [31:0] adr_i;
  logic        ack_o;
  logic        cyc_i;
  logic        err_o;
  logic        lock_i;
  logic        rty_o;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        we_i;

  int checks;
  int failures;

  wb_soc_reg_slave dut (
    .p_clk          (clk),
    .p_resetn       (rst_n),
    .raise_irq      (raise_irq),
    .irq            (irq),
    .module_register(module_register),
    .initialized    (initialized),
    .p_wb_DAT_I     (dat_i),
    .p_wb_DAT_O     (dat_o),
    .p_wb_ADR_I     (adr_i),
    .p_wb_ACK_O     (ack_o),
    .p_wb_CYC_I     (cyc_i),
    .p_wb_ERR_O     (err_o),
    .p_wb_LOCK_I    (lock_i),
    .p_wb_RTY_O     (rty_o),
    .p_wb_SEL_I     (sel_i),
    .p_wb_STB_I     (stb_i),
    .p_wb_WE_I      (we_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus driver: asserts a request on a falling edge and waits (bounded) for ACK; lat=-1 on timeout.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_o === 1'b1) begin
        lat = i;
        rd  = dat_o;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (module_register !== 32'h41000000) begin failures++; $display("FAIL reset_modreg got=%h exp=41000000", module_register); end
    checks++; if (initialized !== 1'b0) begin failures++; $display("FAIL reset_init got=%b exp=0", initialized); end
    xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL reset_reg0_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h41000000) begin failures++; $display("FAIL reset_reg0_read got=%h exp=41000000", rd); end
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_status_read got=%h exp=0", rd); end
    xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h564F0001) begin failures++; $display("FAIL reset_id_read got=%h exp=564f0001", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_reg0_write();
    logic [31:0] rd;
    int lat;
    xfer(1'b1, 32'h0, 32'h40100000, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL reg0_wr_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reg0_wr_ack_dat got=%h exp=0", rd); end
    checks++; if (module_register !== 32'h40100000) begin failures++; $display("FAIL reg0_wr_full got=%h exp=40100000", module_register); end
    checks++; if (initialized !== 1'b1) begin failures++; $display("FAIL reg0_wr_init got=%b exp=1", initialized); end
    xfer(1'b1, 32'h0, 32'hFFFFFFAA, 4'b0001, rd, lat);
    checks++; if (module_register !== 32'h401000AA) begin failures++; $display("FAIL reg0_wr_byte0 got=%h exp=401000aa", module_register); end
    xfer(1'b1, 32'h0, 32'h12345678, 4'b1000, rd, lat);
    checks++; if (module_register !== 32'h121000AA) begin failures++; $display("FAIL reg0_wr_byte3 got=%h exp=121000aa", module_register); end
    xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h121000AA) begin failures++; $display("FAIL reg0_readback got=%h exp=121000aa", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    int lat;
    xfer(1'b1, 32'h4, 32'h1, 4'hF, rd, lat);
    raise_irq = 1'b1;
    @(negedge clk);
    raise_irq = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq); end
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL irq_status got=%h exp=3", rd); end
    xfer(1'b1, 32'h8, 32'h1, 4'b0001, rd, lat);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_w1c_same_cycle got=%b exp=1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c_next_cycle got=%b exp=0", irq); end
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL irq_status_cleared got=%h exp=2", rd); end
  endtask

  task automatic test_mask_collision();
    logic [31:0] rd;
    int lat;
    xfer(1'b1, 32'h4, 32'h0, 4'hF, rd, lat);
    raise_irq = 1'b1;
    @(negedge clk);
    raise_irq = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq_low got=%b exp=0", irq); end
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL mask_pending_kept got=%h exp=3", rd); end
    xfer(1'b1, 32'h4, 32'h1, 4'hF, rd, lat);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_enable_irq got=%b exp=1", irq); end
    // Clear pending, confirm it is clear, then collide a new edge with a W1C.
    xfer(1'b1, 32'h8, 32'h1, 4'b0001, rd, lat);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL collide_precleared got=%h exp=2", rd); end
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h8; dat_i = 32'h1; sel_i = 4'b0001;
    raise_irq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ack_o !== 1'b1) begin failures++; $display("FAIL collide_ack got=%b exp=1", ack_o); end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; raise_irq = 1'b0;
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL collide_set_wins got=%h exp=3", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hC; sel_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      checks++; if (ack_o !== exp_ack[i]) begin failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack_o, exp_ack[i]); end
      checks++; if (dat_o !== (exp_ack[i] ? 32'h564F0001 : 32'h0)) begin failures++; $display("FAIL b2b_dat[%0d] got=%h", i, dat_o); end
      checks++; if ({err_o, rty_o} !== 2'b00) begin failures++; $display("FAIL b2b_err_rty[%0d] got=%b exp=00", i, {err_o, rty_o}); end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_id_write();
    logic [31:0] rd;
    int lat;
    xfer(1'b1, 32'hC, 32'hDEADBEEF, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL id_wr_ack got=%0d exp=1", lat); end
    xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h564F0001) begin failures++; $display("FAIL id_unchanged got=%h exp=564f0001", rd); end
    checks++; if (module_register !== 32'h121000AA) begin failures++; $display("FAIL id_wr_reg0_kept got=%h exp=121000aa", module_register); end
  endtask

  task automatic test_reset_mid();
    bit seen_ack;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0; dat_i = 32'h12345678; sel_i = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_o !== 1'b0) seen_ack = 1'b1;
    end
    checks++; if (seen_ack !== 1'b0) begin failures++; $display("FAIL reset_mid_no_ack got=1 exp=0"); end
    checks++; if (module_register !== 32'h41000000) begin failures++; $display("FAIL reset_mid_modreg got=%h exp=41000000", module_register); end
    checks++; if (initialized !== 1'b0) begin failures++; $display("FAIL reset_mid_init got=%b exp=0", initialized); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_mid_irq got=%b exp=0", irq); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; raise_irq = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; lock_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    test_reset();
    test_reg0_write();
    test_irq();
    test_mask_collision();
    test_back_to_back();
    test_id_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
